// File: rtl/cpa_pkg.sv
// Shared types and segment-bound helpers for the pipelined carry-propagate adder.
// Segment k spans [seg_lo, seg_hi]; seg_hi < seg_lo marks an empty delay-only stage.
package cpa_pkg;

  typedef enum logic {
    CPA_ADD = 1'b0,
    CPA_SUB = 1'b1
  } cpa_op_e;

  function automatic int seg_w(input int bits, input int stages);
    return (bits + stages - 1) / stages;
  endfunction

  function automatic int seg_lo(input int k, input int w);
    return k * w;
  endfunction

  function automatic int seg_hi(input int k, input int w, input int bits);
    return (((k + 1) * w < bits) ? (k + 1) * w : bits) - 1;
  endfunction

endpackage

// File: rtl/cpa_segment.sv
// One adder segment over bits [LO:HI] plus its pipeline register; passes everything else through.
// Latency 1 cycle; holds its register while downstream stalls, ready = !valid || dn_ready.
module cpa_segment
  import cpa_pkg::*;
#(
  parameter int BITS = 40,
  parameter int LO   = 0,
  parameter int HI   = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            up_valid,
  output logic            up_ready,
  output logic            dn_valid,
  input  logic            dn_ready,
  input  logic [BITS-1:0] w_in,
  input  logic [BITS-1:0] b_in,
  input  logic            c_in,
  input  logic            ov_in,
  output logic [BITS-1:0] w_q,
  output logic [BITS-1:0] b_q,
  output logic            c_q,
  output logic            ov_q
);

  localparam bit EMPTY = (HI < LO);

  logic [BITS-1:0] w_n;
  logic            c_n;
  logic            c_msb;
  logic            ov_n;
  logic            load;

  // w carries operand A above this segment and finished result bits below it
  always_comb begin
    w_n   = w_in;
    c_n   = c_in;
    c_msb = c_in;
    for (int i = 0; i < BITS; i++) begin
      if (i >= LO && i <= HI) begin
        c_msb  = c_n;
        w_n[i] = w_in[i] ^ b_in[i] ^ c_n;
        c_n    = (w_in[i] & b_in[i]) | (c_n & (w_in[i] ^ b_in[i]));
      end
    end
    ov_n = EMPTY ? ov_in : (c_msb ^ c_n);
  end

  assign up_ready = !dn_valid || dn_ready;
  assign load     = up_valid && up_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      w_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      ov_q     <= 1'b0;
    end else if (load) begin
      dn_valid <= 1'b1;
      w_q      <= w_n;
      b_q      <= b_in;
      c_q      <= c_n;
      ov_q     <= ov_n;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_cpa.sv
// Pipelined add/subtract: STAGES carry-chained segments, result straight from the last register.
// Latency STAGES cycles, one result per cycle; per-stage valid/ready so bubbles collapse under stall.
module pipelined_cpa
  import cpa_pkg::*;
#(
  parameter int BITS   = 40,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  input  logic            op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] s,
  output logic            co,
  output logic            ovf
);

  localparam int SW = seg_w(BITS, STAGES);

  logic [STAGES:0]           vld;
  logic [STAGES:0]           rdy;
  logic [STAGES:0]           cy;
  logic [STAGES:0]           ov;
  logic [STAGES:0][BITS-1:0] w;
  logic [BITS-1:0]           bb [STAGES+1];

  // Subtract folds into the adder as a + ~b + ~ci, so op is fully consumed here
  assign vld[0]      = in_valid;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];
  assign w[0]        = a;
  assign bb[0]       = (op == CPA_SUB) ? ~b : b;
  assign cy[0]       = (op == CPA_SUB) ? ~ci : ci;
  assign ov[0]       = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    cpa_segment #(
      .BITS(BITS),
      .LO  (seg_lo(k, SW)),
      .HI  (seg_hi(k, SW, BITS))
    ) u_seg (
      .clk     (clk),
      .rst_n   (rst_n),
      .up_valid(vld[k]),
      .up_ready(rdy[k]),
      .dn_valid(vld[k+1]),
      .dn_ready(rdy[k+1]),
      .w_in    (w[k]),
      .b_in    (bb[k]),
      .c_in    (cy[k]),
      .ov_in   (ov[k]),
      .w_q     (w[k+1]),
      .b_q     (bb[k+1]),
      .c_q     (cy[k+1]),
      .ov_q    (ov[k+1])
    );
  end

  assign s   = w[STAGES];
  assign co  = cy[STAGES];
  assign ovf = ov[STAGES];

endmodule
